uart_mmio: RTL
==============

# uart_mmio

Memory-mapped UART peripheral for the pipelined MIPS core. It sits directly downstream of the CPU's MEM stage, next to the data memory. It decodes the MEM-stage `addr`/`wdata`/`rd`/`wr` bus, returns read data in the same cycle, and raises `irq` toward the control unit. Internally it runs an independent 8N1 transmitter and receiver on a shared baud divisor.

## Interface
- `CLK_FREQ`, default 50_000_000, core clock frequency in Hz.
- `BAUD`, default 9600, line rate.
- `DIV = CLK_FREQ/BAUD` is a derived localparam: cycles per bit. It must be ≥ 4 and even.

Ports:
- `clk` in 1: core clock; the single clock domain.
- `reset` in 1: synchronous, active-low.
- `rd` in 1: MEM-stage read strobe.
- `wr` in 1: MEM-stage write strobe.
- `addr` in 32: byte address.
- `wdata` in 32: write data.
- `rdata` out 32: read data, combinational from `addr` and registers.
- `irq` out 1: level interrupt request.
- `UART_RX` in 1: serial input, asynchronous.
- `UART_TX` out 1: serial output, registered.

## Operation
- Register map:
  - `0x4000_0018` TXD: a write of `[7:0]` starts a frame if TX is idle. A write while busy is ignored entirely. A read returns the last accepted byte.
  - `0x4000_001C` RXD: a read returns `{24'b0, rx_byte}`.
  - `0x4000_0020` CON, with these bits:
    - bit0 TX interrupt enable (R/W).
    - bit1 RX interrupt enable (R/W).
    - bit2 TX_STATUS (sticky).
    - bit3 RX_STATUS (sticky).
    - bit4 TX_BUSY (read-only).
    - bit5 framing error FE (sticky).
    - bit6 overrun OVR (sticky).
    - Writes affect bits [1:0] only.
- Read side effects occur at the clock edge where `rd=1`:
  - Reading RXD clears RX_STATUS and OVR.
  - Reading CON clears TX_STATUS and FE.
- Any other address: `rdata=0` and writes are ignored. When `rd` and `wr` are both high, the write executes and `rdata` stays valid.
- `irq = (CON[0] & TX_STATUS) | (CON[1] & RX_STATUS)`, combinational from registers.
- TX FSM: states IDLE → START → DATA → STOP → IDLE.
  - Each state lasts `DIV` cycles; a bit counter (0..7) runs in DATA, LSB first.
  - `UART_TX` outputs 0 in START, the data bit in DATA, 1 in STOP and IDLE.
  - TX_BUSY=1 whenever the FSM is not in IDLE.
- RX path:
  - A 2-flop synchronizer on `UART_RX` resets to 1.
  - IDLE: a synchronized 0 enters START, with the counter loaded to `DIV/2-1`.
  - START: at the mid-bit sample, still 0 → DATA; a 1 is treated as a glitch → IDLE.
  - DATA: sample every `DIV` cycles, 8 bits, LSB first.
  - STOP: sample once more after `DIV`. If the sample is 1, latch `rx_byte` and set RX_STATUS; if RX_STATUS was already 1, also set OVR. If the sample is 0, discard the byte, set FE, and leave `rx_byte` unchanged.
  - Return to IDLE immediately, then wait for the line to be 1 before accepting a new start.
- Simultaneous events:
  - A status clear-on-read and a status set in the same cycle: the set wins.
  - A CON write and a status event in the same cycle: both take effect, because they touch disjoint bits.

## Timing
- Reset (synchronous, `reset=0` at an edge) forces the following, regardless of FSM state, including mid-frame:
  - Both FSMs to IDLE, all counters to 0.
  - CON=0, TXD=0, RXD=0.
  - `UART_TX=1`, `irq=0`, synchronizer flops to 1.
- TX latency:
  - `UART_TX` falls in the first cycle after the accepting write edge.
  - The frame is exactly `10*DIV` cycles.
  - TX_STATUS is set and TX_BUSY is cleared at the edge that ends STOP.
  - A new TXD write is accepted from the following cycle.
- RX latency: RX_STATUS rises `2 + DIV/2 + 9*DIV` (±1) cycles after the pin's falling start edge.
- `rdata` and `irq` have zero-cycle combinational paths; the CPU samples them in the MEM stage.

## Structure
- Shared package `uart_pkg`:
  - Address constants: `UART_TXD_ADDR`, `UART_RXD_ADDR`, `UART_CON_ADDR`.
  - CON bit indices.
  - TX/RX state encodings: IDLE/START/DATA/STOP, 2-bit.
- One natural sub-module, `uart_rx_core`: synchronizer, RX FSM and baud counter. It outputs `rx_valid` (1-cycle pulse), `rx_data[7:0]` and `rx_ferr` (pulse).
- The TX FSM, register file and address decode stay in `uart_mmio`.

## Test plan
All scenarios use `CLK_FREQ=16`, `BAUD=1`, so `DIV=16`.
- Reset: hold `reset=0` 3 cycles → `UART_TX=1`, `irq=0`, CON reads 0x00, RXD reads 0x00.
- TX: write CON=0x01, then TXD=0x55 → `UART_TX` shows 0 for 16 cycles, then bits 1,0,1,0,1,0,1,0 for 16 cycles each, then stop 1. At cycle 160 `irq=1`. A CON read returns 0x05, and the next read returns 0x01 with `irq=0`.
- RX: CON=0x02, drive a 0xA3 8N1 frame at 16 cycles/bit → RX_STATUS rises at 154±1 cycles, `irq=1`, RXD reads 0xA3. A CON read afterwards shows bit3=0.
- Glitch and framing error:
  - A 4-cycle low pulse on `UART_RX` → no status change.
  - A frame with data 0x3C and stop bit 0 → FE=1, RX_STATUS=0, RXD unchanged.
- Busy write: write TXD=0x12, then TXD=0x34 20 cycles later → only 0x12 is serialized, TXD reads 0x12, a single TX_STATUS set.
- Overrun and reset mid-frame:
  - Receive two frames without reading RXD → RXD holds the second byte, OVR=1.
  - Assert `reset` during TX data bit 3 → `UART_TX=1` the next cycle, CON=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register addresses,
// CON bit positions and the 2-bit state encoding used by both serial FSMs.
package uart_pkg;

   localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
   localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
   localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

   localparam int CON_TXIE = 0;
   localparam int CON_RXIE = 1;
   localparam int CON_TXST = 2;
   localparam int CON_RXST = 3;
   localparam int CON_BUSY = 4;
   localparam int CON_FE   = 5;
   localparam int CON_OVR  = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uartState_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling FSM and baud counter.
// Reports a good byte or a framing error as single-cycle pulses.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DIV = 16
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_rx,
   output logic       o_rxValid,
   output logic [7:0] o_rxData,
   output logic       o_rxFerr
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          r_sync1;
   logic          r_sync2;
   uartState_t    r_state;
   uartState_t    w_stateNext;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cntNext;
   logic [2:0]    r_bitIdx;
   logic [2:0]    w_bitNext;
   logic [7:0]    r_shift;
   logic [7:0]    w_shiftNext;
   logic          r_armed;
   logic          w_armedNext;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_bitIdx <= '0;
         r_shift  <= '0;
         r_armed  <= 1'b0;
      end else begin
         r_sync1  <= i_rx;
         r_sync2  <= r_sync1;
         r_state  <= w_stateNext;
         r_cnt    <= w_cntNext;
         r_bitIdx <= w_bitNext;
         r_shift  <= w_shiftNext;
         r_armed  <= w_armedNext;
      end
   end

   // r_armed blocks a new start until the line has been seen high, so a
   // stuck-low line after a framing error cannot retrigger immediately.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_bitNext   = r_bitIdx;
      w_shiftNext = r_shift;
      w_armedNext = r_armed;
      unique case (r_state)
         IDLE: begin
            if (r_sync2) begin
               w_armedNext = 1'b1;
            end else if (r_armed) begin
               w_stateNext = START;
               w_cntNext   = CNT_HALF;
            end
         end
         START: begin
            if (r_cnt != '0) begin
               w_cntNext = r_cnt - CNT_ONE;
            end else if (r_sync2) begin
               w_stateNext = IDLE;
            end else begin
               w_stateNext = DATA;
               w_cntNext   = CNT_FULL;
               w_bitNext   = '0;
            end
         end
         DATA: begin
            if (r_cnt != '0) begin
               w_cntNext = r_cnt - CNT_ONE;
            end else begin
               w_shiftNext = {r_sync2, r_shift[7:1]};
               w_cntNext   = CNT_FULL;
               if (r_bitIdx == 3'd7) begin
                  w_stateNext = STOP;
               end else begin
                  w_bitNext = r_bitIdx + 3'd1;
               end
            end
         end
         STOP: begin
            if (r_cnt != '0) begin
               w_cntNext = r_cnt - CNT_ONE;
            end else begin
               w_stateNext = IDLE;
               w_cntNext   = '0;
               w_bitNext   = '0;
               w_armedNext = r_sync2;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_comb begin
      o_rxValid = (r_state == STOP) && (r_cnt == '0) && r_sync2;
      o_rxFerr  = (r_state == STOP) && (r_cnt == '0) && !r_sync2;
      o_rxData  = r_shift;
   end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART for the MIPS MEM stage: address decode, register
// file, interrupt and the transmitter FSM; reception is in uart_rx_core.
module uart_mmio
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq,
   input  logic        UART_RX,
   output logic        UART_TX
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   uartState_t    r_txState;
   uartState_t    w_txStateNext;
   logic [CW-1:0] r_txCnt;
   logic [CW-1:0] w_txCntNext;
   logic [2:0]    r_txBit;
   logic [2:0]    w_txBitNext;
   logic [7:0]    r_txd;
   logic          r_uartTx;
   logic          w_txLineNext;
   logic          w_txDone;
   logic          w_txBusy;
   logic [1:0]    r_conIe;
   logic          r_txStatus;
   logic          r_rxStatus;
   logic          r_fe;
   logic          r_ovr;
   logic [7:0]    r_rxByte;
   logic          w_selTxd;
   logic          w_selRxd;
   logic          w_selCon;
   logic          w_txAccept;
   logic          w_rxValid;
   logic          w_rxFerr;
   logic [7:0]    w_rxData;
   logic          w_unusedBits;

   assign w_selTxd     = (addr == UART_TXD_ADDR);
   assign w_selRxd     = (addr == UART_RXD_ADDR);
   assign w_selCon     = (addr == UART_CON_ADDR);
   assign w_txAccept   = wr && w_selTxd && (r_txState == IDLE);
   assign w_unusedBits = ^wdata[31:8];

   uart_rx_core #(.DIV(DIV)) u_rxCore (
      .clk       (clk),
      .reset     (reset),
      .i_rx      (UART_RX),
      .o_rxValid (w_rxValid),
      .o_rxData  (w_rxData),
      .o_rxFerr  (w_rxFerr)
   );

   // UART_TX is registered from the next state, so the line drops in the
   // very cycle after the accepting write edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_txState <= IDLE;
         r_txCnt   <= '0;
         r_txBit   <= '0;
         r_uartTx  <= 1'b1;
      end else begin
         r_txState <= w_txStateNext;
         r_txCnt   <= w_txCntNext;
         r_txBit   <= w_txBitNext;
         r_uartTx  <= w_txLineNext;
      end
   end

   always_comb begin
      w_txStateNext = r_txState;
      w_txCntNext   = r_txCnt;
      w_txBitNext   = r_txBit;
      unique case (r_txState)
         IDLE: begin
            if (w_txAccept) begin
               w_txStateNext = START;
               w_txCntNext   = '0;
               w_txBitNext   = '0;
            end
         end
         START: begin
            if (r_txCnt == CNT_LAST) begin
               w_txStateNext = DATA;
               w_txCntNext   = '0;
            end else begin
               w_txCntNext = r_txCnt + CNT_ONE;
            end
         end
         DATA: begin
            if (r_txCnt == CNT_LAST) begin
               w_txCntNext = '0;
               if (r_txBit == 3'd7) begin
                  w_txStateNext = STOP;
               end else begin
                  w_txBitNext = r_txBit + 3'd1;
               end
            end else begin
               w_txCntNext = r_txCnt + CNT_ONE;
            end
         end
         STOP: begin
            if (r_txCnt == CNT_LAST) begin
               w_txStateNext = IDLE;
               w_txCntNext   = '0;
            end else begin
               w_txCntNext = r_txCnt + CNT_ONE;
            end
         end
         default: w_txStateNext = IDLE;
      endcase
   end

   always_comb begin
      w_txBusy = (r_txState != IDLE);
      w_txDone = (r_txState == STOP) && (r_txCnt == CNT_LAST);
      unique case (w_txStateNext)
         START:   w_txLineNext = 1'b0;
         DATA:    w_txLineNext = r_txd[w_txBitNext];
         default: w_txLineNext = 1'b1;
      endcase
   end

   assign UART_TX = r_uartTx;

   // Status sets take priority over clear-on-read; CON writes only reach
   // the enable bits, so they never collide with status updates.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_conIe    <= '0;
         r_txd      <= '0;
         r_rxByte   <= '0;
         r_txStatus <= 1'b0;
         r_rxStatus <= 1'b0;
         r_fe       <= 1'b0;
         r_ovr      <= 1'b0;
      end else begin
         if (wr && w_selCon) r_conIe <= wdata[1:0];
         if (w_txAccept) r_txd <= wdata[7:0];
         if (w_txDone) r_txStatus <= 1'b1;
         else if (rd && w_selCon) r_txStatus <= 1'b0;
         if (w_rxFerr) r_fe <= 1'b1;
         else if (rd && w_selCon) r_fe <= 1'b0;
         if (w_rxValid) r_rxByte <= w_rxData;
         if (w_rxValid) r_rxStatus <= 1'b1;
         else if (rd && w_selRxd) r_rxStatus <= 1'b0;
         if (w_rxValid && r_rxStatus) r_ovr <= 1'b1;
         else if (rd && w_selRxd) r_ovr <= 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      if (w_selTxd) begin
         rdata = {24'd0, r_txd};
      end else if (w_selRxd) begin
         rdata = {24'd0, r_rxByte};
      end else if (w_selCon) begin
         rdata[CON_TXIE] = r_conIe[0];
         rdata[CON_RXIE] = r_conIe[1];
         rdata[CON_TXST] = r_txStatus;
         rdata[CON_RXST] = r_rxStatus;
         rdata[CON_BUSY] = w_txBusy;
         rdata[CON_FE]   = r_fe;
         rdata[CON_OVR]  = r_ovr;
      end
   end

   assign irq = (r_conIe[0] & r_txStatus) | (r_conIe[1] & r_rxStatus);

endmodule
